// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core and a
// host burst port. The core wins every cycle; the host advances one beat per
// free cycle. Optional starvation guard: define DMEM_ARB_STARVE_EN to force a
// host beat after STARVE_LIMIT consecutive blocked burst cycles.
module dmem_arbiter #(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    input  logic          host_start,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_len,
    input  logic [DW-1:0] host_wdata,
    output logic          host_beat,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          host_busy,
    output logic          host_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    remain_q, remain_d;
    logic          we_q, we_d;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic          force_beat;
    logic          beat;

`ifdef DMEM_ARB_STARVE_EN
    logic [7:0] starve_q, starve_d;

    // Starve guard: count burst cycles lost to the core, force a beat at the limit
    always_comb begin
        force_beat = (state_q == BURST) && (starve_q == 8'(STARVE_LIMIT));
        starve_d   = '0;
        if (state_q == BURST && !beat) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Starve counter register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_beat = 1'b0;
`endif

    // Burst sequencing and core/host arbitration
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        we_d     = we_q;
        beat     = 1'b0;
        core_gnt = core_req;
        case (state_q)
            IDLE: begin
                if (host_start) begin
                    we_d     = host_we;
                    addr_d   = host_addr;
                    remain_d = host_len;
                    state_d  = (host_len == 8'd0) ? DONE : BURST;
                end
            end
            BURST: begin
                beat     = !core_req || force_beat;
                core_gnt = core_req && !beat;
                if (beat) begin
                    addr_d   = addr_q + AW'(1);
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory port mux: host beat takes the port, otherwise the core drives it
    always_comb begin
        mem_addr  = core_addr;
        mem_we    = core_we && core_gnt;
        mem_wdata = core_wdata;
        if (beat) begin
            mem_addr  = addr_q;
            mem_we    = we_q;
            mem_wdata = host_wdata;
        end
    end

    // State, burst pointer and registered read-data path
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            we_q     <= we_d;
            rvalid_q <= beat && !we_q;
            if (beat && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign host_beat   = beat;
    assign host_rdata  = rdata_q;
    assign host_rvalid = rvalid_q;
    assign host_busy   = (state_q != IDLE);
    assign host_done   = (state_q == DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_dmem_arbiter;

    localparam int LIM = 3;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       core_req, core_we, core_gnt;
    logic [7:0] core_addr, core_wdata;
    logic       host_start, host_we, host_beat, host_rvalid, host_busy, host_done;
    logic [7:0] host_addr, host_len, host_wdata, host_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    int n_chk = 0;
    int n_err = 0;

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(LIM)) dut (
        .Clk(Clk), .Reset(Reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt),
        .host_start(host_start), .host_we(host_we), .host_addr(host_addr),
        .host_len(host_len), .host_wdata(host_wdata), .host_beat(host_beat),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_busy(host_busy),
        .host_done(host_done), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    // Data memory with combinational read
    logic [7:0] mem [256];
    logic       mem_clear = 1'b1;
    assign mem_rdata = mem[mem_addr];
    always @(posedge Clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [7:0] ref_mem [256];
    int   m_mode;   // 0 no burst, 1 burst running, 2 done cycle
    int   m_addr, m_left, m_starve;
    logic m_we;
    logic [7:0] m_rdata;
    logic m_rvalid;

    initial begin
        bit frc, e_beat, e_gnt;
        int o_mode;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        m_mode = 0; m_addr = 0; m_left = 0; m_starve = 0;
        m_we = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                m_mode = 0; m_addr = 0; m_left = 0; m_starve = 0;
                m_we = 1'b0; m_rdata = 8'h00; m_rvalid = 1'b0;
            end
            frc    = STARVE_ON && (m_mode == 1) && (m_starve == LIM);
            e_beat = (m_mode == 1) && (!core_req || frc);
            e_gnt  = core_req && !e_beat;
            check("m_beat", host_beat, e_beat);
            check("m_gnt", core_gnt, e_gnt);
            check("m_addr", mem_addr, e_beat ? 8'(m_addr) : core_addr);
            check("m_we", mem_we, e_beat ? m_we : (core_we && e_gnt));
            check("m_wdata", mem_wdata, e_beat ? host_wdata : core_wdata);
            check("m_busy", host_busy, m_mode != 0);
            check("m_done", host_done, m_mode == 2);
            check("m_rvalid", host_rvalid, m_rvalid);
            check("m_rdata", host_rdata, m_rdata);
            // advance to the state seen after the coming rising edge
            if (e_gnt && core_we) ref_mem[core_addr] = core_wdata;
            if (!Reset) begin
                o_mode   = m_mode;
                m_rvalid = e_beat && !m_we;
                if (e_beat) begin
                    if (m_we) ref_mem[m_addr] = host_wdata;
                    else      m_rdata = ref_mem[m_addr];
                end
                m_starve = (o_mode == 1 && !e_beat) ? m_starve + 1 : 0;
                if (o_mode == 0) begin
                    if (host_start) begin
                        m_we = host_we; m_addr = host_addr; m_left = host_len;
                        m_mode = (host_len == 0) ? 2 : 1;
                    end
                end else if (o_mode == 1) begin
                    if (e_beat) begin
                        m_addr = (m_addr + 1) % 256;
                        m_left = m_left - 1;
                        if (m_left == 0) m_mode = 2;
                    end
                end else begin
                    m_mode = 0;
                end
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_burst(input logic we, input logic [7:0] a, input logic [7:0] len);
        host_start = 1'b1; host_we = we; host_addr = a; host_len = len;
        tick();
        host_start = 1'b0;
    endtask

    initial begin
        int nrd, nb, last_beat, bq[$];
        bit seen, busy_ok;
        Reset = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        host_start = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_len = 8'h00; host_wdata = 8'h00;
        #3;
        check("rst_gnt", core_gnt, 1);
        check("rst_busy", host_busy, 0);
        check("rst_beat", host_beat, 0);
        check("rst_done", host_done, 0);
        check("rst_rvalid", host_rvalid, 0);
        check("rst_rdata", host_rdata, 0);
        tick();
        mem_clear = 1'b0; core_req = 1'b0;
        tick();
        Reset = 1'b0;
        tick();

        // write burst, no core traffic
        start_burst(1'b1, 8'h10, 8'd4);
        for (int i = 0; i < 4; i++) begin
            host_wdata = 8'(8'hA0 + i);
            #1; check("s1_beat", host_beat, 1);
            tick();
        end
        #1; check("s1_done", host_done, 1); check("s1_busy", host_busy, 1);
        tick(); #1; check("s1_done_end", host_done, 0); check("s1_idle", host_busy, 0);
        for (int i = 0; i < 4; i++) check("s1_mem", mem[8'h10 + i], 8'(8'hA0 + i));

        // read burst with the core on alternate cycles
        tick();
        start_burst(1'b0, 8'h10, 8'd3);
        nrd = 0; nb = 0; seen = 0; last_beat = -10;
        for (int c = 0; c < 30 && !seen; c++) begin
            core_req = c[0]; core_we = 1'b0; core_addr = 8'(8'h20 + c);
            #1;
            if (core_req) check("s2_gnt", core_gnt, 1);
            if (host_beat) begin nb++; last_beat = c; bq.push_back(c); end
            if (host_rvalid) begin
                check("s2_rdata", host_rdata, 8'(8'hA0 + nrd));
                check("s2_rv_lat", c, (bq.size() > 0) ? bq.pop_front() + 1 : -1);
                nrd++;
            end
            if (host_done) begin seen = 1; check("s2_done_lat", c, last_beat + 1); end
            tick();
        end
        core_req = 1'b0;
        check("s2_done_seen", seen, 1);
        check("s2_reads", nrd, 3);
        check("s2_beats", nb, 3);

        // address wrap and zero-length burst
        start_burst(1'b1, 8'hFE, 8'd3);
        for (int i = 0; i < 3; i++) begin
            host_wdata = 8'(8'h11 * (i + 1));
            #1; check("s3_beat", host_beat, 1);
            tick();
        end
        #1; check("s3_done", host_done, 1);
        tick();
        check("s3_mem_fe", mem[8'hFE], 8'h11);
        check("s3_mem_ff", mem[8'hFF], 8'h22);
        check("s3_mem_00", mem[8'h00], 8'h33);
        check("s3_mem_01", mem[8'h01], 8'h00);
        start_burst(1'b1, 8'h05, 8'd0);
        #1; check("s3_z_done", host_done, 1); check("s3_z_beat", host_beat, 0);
        tick(); #1; check("s3_z_end", host_done, 0); check("s3_z_beat2", host_beat, 0);
        check("s3_z_mem", mem[8'h05], 8'h00);

        // host_start during a burst is ignored
        tick();
        start_burst(1'b1, 8'h80, 8'd3);
        host_wdata = 8'h90; #1; check("s6_beat0", host_beat, 1);
        tick();
        host_start = 1'b1; host_we = 1'b0; host_addr = 8'hC0; host_len = 8'd7;
        host_wdata = 8'h91; #1; check("s6_beat1", host_beat, 1);
        tick();
        host_start = 1'b0;
        host_wdata = 8'h92; #1; check("s6_beat2", host_beat, 1);
        tick();
        #1; check("s6_done", host_done, 1);
        tick(); #1; check("s6_idle", host_busy, 0);
        for (int i = 0; i < 3; i++) check("s6_mem", mem[8'h80 + i], 8'(8'h90 + i));

        // reset after 2 of 5 beats
        tick();
        start_burst(1'b1, 8'h40, 8'd5);
        for (int i = 0; i < 2; i++) begin
            host_wdata = 8'(8'h60 + i);
            tick();
        end
        Reset = 1'b1; core_req = 1'b1; core_we = 1'b0; host_wdata = 8'h62;
        #1;
        check("s5_beat", host_beat, 0); check("s5_busy", host_busy, 0);
        check("s5_done", host_done, 0); check("s5_rvalid", host_rvalid, 0);
        check("s5_rdata", host_rdata, 0); check("s5_gnt", core_gnt, 1);
        tick();
        Reset = 1'b0; core_req = 1'b0;
        #1; check("s5_nodone", host_done, 0); check("s5_nobusy", host_busy, 0);
        tick();
        start_burst(1'b1, 8'h50, 8'd1);
        host_wdata = 8'h77; #1; check("s5_new_beat", host_beat, 1);
        tick(); #1; check("s5_new_done", host_done, 1);
        tick();
        check("s5_m40", mem[8'h40], 8'h60); check("s5_m41", mem[8'h41], 8'h61);
        check("s5_m42", mem[8'h42], 8'h00); check("s5_m43", mem[8'h43], 8'h00);
        check("s5_m44", mem[8'h44], 8'h00); check("s5_m50", mem[8'h50], 8'h77);

        // starvation with the core hogging the port
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h33;
        start_burst(1'b0, 8'h10, 8'd10);
`ifdef DMEM_ARB_STARVE_EN
        for (int k = 0; k < 20; k++) begin
            #1;
            check("st_beat", host_beat, (k % 4) == 3);
            check("st_gnt", core_gnt, (k % 4) != 3);
            tick();
        end
`else
        nb = 0; busy_ok = 1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (host_beat) nb++;
            if (!host_busy) busy_ok = 0;
            tick();
        end
        check("st_nobeats", nb, 0);
        check("st_busy", busy_ok, 1);
`endif
        core_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            #1; if (host_done) seen = 1;
            tick();
        end
        check("st_done_seen", seen, 1);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            core_req   = ($urandom % 3) != 0;
            core_we    = $urandom % 2;
            core_addr  = 8'($urandom);
            core_wdata = 8'($urandom);
            host_wdata = 8'($urandom);
            host_start = ($urandom % 6) == 0;
            host_we    = $urandom % 2;
            host_addr  = 8'($urandom);
            host_len   = 8'($urandom % 6);
            Reset      = ($urandom % 250) == 0;
            tick();
        end
        Reset = 1'b0; core_req = 1'b0; host_start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
